smj_dealer: RTL

Hand-assembly front end for the SMJ hand evaluator. It accepts tiles one per cycle over a valid/ready stream and checks each tile's legality. It then presents a complete 5-tile hand on the SMJ `hand_n0..hand_n4` inputs and captures SMJ's 2-bit verdict. The verdict goes back to the requester over a valid/ready response channel. The block sits between the tile source (testbench PATTERN or an upstream shuffler) and the combinational SMJ core.

---
 rtl/smj_pkg.sv | 24 ++
 rtl/smj_tile_legal.sv | 24 ++
 rtl/smj_dealer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/smj_pkg.sv
// Shared types and constants for the SMJ dealer front end.
// Used by the dealer, its tile legality checker and the reference pattern.
package smj_pkg;

    typedef logic [5:0] tile_t;

    localparam logic [1:0] SUIT_MAN   = 2'd0;
    localparam logic [1:0] SUIT_PIN   = 2'd1;
    localparam logic [1:0] SUIT_SOU   = 2'd2;
    localparam logic [1:0] SUIT_HONOR = 2'd3;

    localparam logic [3:0] RANK_MAX_NUM   = 4'd9;
    localparam logic [3:0] RANK_MAX_HONOR = 4'd7;

    localparam int HAND_SIZE = 5;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRIVE   = 2'd1,
        SETTLE  = 2'd2,
        RESP    = 2'd3
    } state_e;

endpackage

// File: rtl/smj_tile_legal.sv
// Combinational tile legality: numbered suits take ranks 1..9, honors 1..7.
// Shared with the reference pattern so both sides agree on what is legal.
module smj_tile_legal
    import smj_pkg::*;
(
    input  tile_t tile,
    output logic  legal
);

    logic [1:0] suit;
    logic [3:0] rank;

    always_comb begin
        suit  = tile[5:4];
        rank  = tile[3:0];
        legal = 1'b0;
        if (suit == SUIT_HONOR) begin
            legal = (rank != 4'd0) && (rank <= RANK_MAX_HONOR);
        end else begin
            legal = (rank != 4'd0) && (rank <= RANK_MAX_NUM);
        end
    end

endmodule

// File: rtl/smj_dealer.sv
// Hand-assembly front end for the SMJ evaluator: collects 5 tiles, drives SMJ, returns the verdict.
// Build option SMJ_DEAL_SORT_EN: keep the tile buffer insertion-sorted (ascending code).
//
// state   | meaning
// COLLECT | accept tiles into the buffer, track legality
// DRIVE   | load hand_n* from buffer, or flag an illegal hand straight to RESP
// SETTLE  | down-count SETTLE_CYC while SMJ settles, then capture its verdict
// RESP    | hold response until out_valid && out_ready
module smj_dealer
    import smj_pkg::*;
#(
    parameter int SETTLE_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [5:0] in_tile,
    output logic       in_ready,
    output logic [5:0] hand_n0,
    output logic [5:0] hand_n1,
    output logic [5:0] hand_n2,
    output logic [5:0] hand_n3,
    output logic [5:0] hand_n4,
    input  logic [1:0] smj_result,
    output logic       out_valid,
    output logic [1:0] out_data,
    output logic       out_err,
    input  logic       out_ready
);

    state_e     state_q, state_nxt;
    tile_t      buf_q   [HAND_SIZE];
    tile_t      buf_nxt [HAND_SIZE];
    logic [2:0] count_q;
    logic       bad_q;
    logic [1:0] wait_q;

    logic       accept;
    logic       last_tile;
    logic       tile_ok;
    logic       five_same;
    logic       load_hand;
    logic       cap_result;
    logic       flag_err;
    logic       resp_done;

    smj_tile_legal u_legal (
        .tile  (in_tile),
        .legal (tile_ok)
    );

    assign in_ready  = (state_q == COLLECT);
    assign accept    = in_valid && in_ready;
    assign last_tile = (count_q == 3'(HAND_SIZE - 1));
    // In either buffer order, four held copies of the incoming code means five identical.
    assign five_same = (buf_q[0] == in_tile) && (buf_q[1] == in_tile) &&
                       (buf_q[2] == in_tile) && (buf_q[3] == in_tile);

`ifdef SMJ_DEAL_SORT_EN
    logic [HAND_SIZE-1:0] gt;

    always_comb begin
        for (int i = 0; i < HAND_SIZE; i++) begin
            gt[i] = (3'(i) < count_q) && (buf_q[i] > in_tile);
        end
        // Entries not above the new tile stay; larger ones shift up; the gap takes the new tile.
        buf_nxt[0] = (count_q != 3'd0 && !gt[0]) ? buf_q[0] : in_tile;
        for (int i = 1; i < HAND_SIZE; i++) begin
            if ((3'(i) < count_q) && !gt[i]) begin
                buf_nxt[i] = buf_q[i];
            end else if (gt[i-1]) begin
                buf_nxt[i] = buf_q[i-1];
            end else begin
                buf_nxt[i] = in_tile;
            end
        end
    end
`else
    always_comb begin
        for (int i = 0; i < HAND_SIZE; i++) begin
            buf_nxt[i] = (3'(i) == count_q) ? in_tile : buf_q[i];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        load_hand  = 1'b0;
        cap_result = 1'b0;
        flag_err   = 1'b0;
        resp_done  = 1'b0;
        case (state_q)
            COLLECT: begin
                if (accept && last_tile) begin
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (bad_q) begin
                    flag_err  = 1'b1;
                    state_nxt = RESP;
                end else begin
                    load_hand = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (wait_q == 2'd0) begin
                    cap_result = 1'b1;
                    state_nxt  = RESP;
                end
            end
            RESP: begin
                if (out_valid && out_ready) begin
                    resp_done = 1'b1;
                    state_nxt = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HAND_SIZE; i++) begin
                buf_q[i] <= '0;
            end
            count_q   <= '0;
            bad_q     <= 1'b0;
            wait_q    <= '0;
            hand_n0   <= '0;
            hand_n1   <= '0;
            hand_n2   <= '0;
            hand_n3   <= '0;
            hand_n4   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else begin
            if (accept) begin
                for (int i = 0; i < HAND_SIZE; i++) begin
                    buf_q[i] <= buf_nxt[i];
                end
                if (!last_tile) begin
                    count_q <= count_q + 3'd1;
                end
                bad_q <= bad_q | ~tile_ok | (last_tile & five_same);
            end
            if (load_hand) begin
                hand_n0 <= buf_q[0];
                hand_n1 <= buf_q[1];
                hand_n2 <= buf_q[2];
                hand_n3 <= buf_q[3];
                hand_n4 <= buf_q[4];
                wait_q  <= 2'(SETTLE_CYC);
            end
            if (state_q == SETTLE && wait_q != 2'd0) begin
                wait_q <= wait_q - 2'd1;
            end
            if (cap_result) begin
                out_valid <= 1'b1;
                out_data  <= smj_result;
                out_err   <= 1'b0;
            end
            if (flag_err) begin
                out_valid <= 1'b1;
                out_data  <= 2'd0;
                out_err   <= 1'b1;
            end
            if (resp_done) begin
                out_valid <= 1'b0;
                count_q   <= '0;
                bad_q     <= 1'b0;
            end
        end
    end

endmodule
